// File: rtl/matrix_pkg.sv
// matrix_pkg: FSM states, accumulator sizing, operand slice offsets and the element fit function.
// MULT_SAT_EN selects saturating results; otherwise final elements wrap to W bits.
package matrix_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, FINISH} state_t;
  function automatic int accw(input int w, input int n);
    return 2*w + $clog2(n);
  endfunction
  function automatic int rm_off(input int i, input int j, input int n, input int w);
    return (n*n-1-(i*n+j))*w;
  endfunction
  function automatic int cm_off(input int i, input int j, input int n, input int w);
    return (n*n-1-(j*n+i))*w;
  endfunction
  function automatic logic out_of_range(input logic signed [63:0] v, input int w);
    return v > ((64'sd1 <<< (w-1)) - 64'sd1) || v < -(64'sd1 <<< (w-1));
  endfunction
  function automatic logic signed [63:0] fit(input logic signed [63:0] v, input int w);
`ifdef MULT_SAT_EN
    logic signed [63:0] mx, mn;
    mx = (64'sd1 <<< (w-1)) - 64'sd1;
    mn = -(64'sd1 <<< (w-1));
    return v > mx ? mx : v < mn ? mn : v;
`else
    return v & ((64'sd1 <<< w) - 64'sd1);
`endif
  endfunction
endpackage

// File: rtl/mult_m_seq_if.sv
// mult_m_seq_if: start/busy/done handshake, operand matrices and result bus of mult_m_seq.
interface mult_m_seq_if #(parameter int N = 5, parameter int W = 8);
  logic start;
  logic [$clog2(N+1)-1:0] size;
  logic [N*N*W-1:0] lin, col, n_out;
  logic busy, done, ovf;
  modport master(output start, size, lin, col, input busy, done, n_out, ovf);
  modport slave(input start, size, lin, col, output busy, done, n_out, ovf);
endinterface

// File: rtl/mult_m_seq_mac.sv
// mac_elem: signed W x W multiply into an ACCW-bit accumulator with clear and enable.
module mac_elem #(parameter int W = 8, parameter int ACCW = 19) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [ACCW-1:0] acc
);
  logic signed [2*W-1:0] prod;
  logic signed [ACCW-1:0] acc_d, acc_q;
  always_comb begin
    prod = a * b;
    acc_d = clr ? '0 : en ? acc_q + ACCW'(prod) : acc_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/mult_m_seq.sv
// mult_m_seq: sequential m x m signed matrix multiply over one shared MAC, start/busy/done handshake.
// Final elements wrap, or saturate when MULT_SAT_EN is defined; ovf flags any out-of-range element.
module mult_m_seq import matrix_pkg::*; #(parameter int N = 5, parameter int W = 8) (
  input logic clk,
  input logic rst,
  mult_m_seq_if.slave bus
);
  localparam int ACCW = accw(W, N);
  localparam int SW = $clog2(N+1);
  localparam int MW = N*N*W;
  state_t state_d, state_q;
  logic [MW-1:0] lin_d, lin_q, col_d, col_q, res_d, res_q, n_out_d, n_out_q;
  logic [SW-1:0] m_d, m_q, i_d, i_q, j_d, j_q, k_d, k_q;
  logic busy_d, busy_q, done_d, done_q, ovf_d, ovf_q, ovf_acc_d, ovf_acc_q;
  logic last_i, last_j, last_k;
  logic signed [W-1:0] a, b;
  logic signed [ACCW-1:0] acc;
  logic signed [63:0] wide, fitv;
  mac_elem #(.W(W), .ACCW(ACCW)) u_mac (
    .clk(clk), .rst(rst),
    .clr(state_q == LOAD || state_q == WRITE), .en(state_q == MAC),
    .a(a), .b(b), .acc(acc)
  );
  always_comb begin
    state_d = state_q;
    lin_d = lin_q;
    col_d = col_q;
    res_d = res_q;
    n_out_d = n_out_q;
    m_d = m_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    busy_d = busy_q;
    done_d = 1'b0;
    ovf_d = ovf_q;
    ovf_acc_d = ovf_acc_q;
    last_i = i_q == m_q - SW'(1);
    last_j = j_q == m_q - SW'(1);
    last_k = k_q == m_q - SW'(1);
    a = lin_q[rm_off(int'(i_q), int'(k_q), N, W) +: W];
    b = col_q[cm_off(int'(k_q), int'(j_q), N, W) +: W];
    wide = 64'(acc);
    fitv = fit(wide, W);
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = LOAD;
        lin_d = bus.lin;
        col_d = bus.col;
        m_d = (bus.size == '0 || int'(bus.size) > N) ? SW'(N) : bus.size;
        busy_d = 1'b1;
        ovf_d = 1'b0;
      end
      LOAD: begin
        state_d = MAC;
        i_d = '0;
        j_d = '0;
        k_d = '0;
        res_d = '0;
        ovf_acc_d = 1'b0;
      end
      MAC: begin
        k_d = last_k ? '0 : k_q + SW'(1);
        state_d = last_k ? WRITE : MAC;
      end
      WRITE: begin
        res_d[rm_off(int'(i_q), int'(j_q), N, W) +: W] = fitv[W-1:0];
        ovf_acc_d = ovf_acc_q | out_of_range(wide, W);
        j_d = last_j ? '0 : j_q + SW'(1);
        i_d = last_j ? (last_i ? '0 : i_q + SW'(1)) : i_q;
        state_d = (last_i && last_j) ? FINISH : MAC;
      end
      FINISH: begin
        state_d = IDLE;
        n_out_d = res_q;
        ovf_d = ovf_acc_q;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      lin_q <= '0;
      col_q <= '0;
      res_q <= '0;
      n_out_q <= '0;
      m_q <= '0;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      ovf_acc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lin_q <= lin_d;
      col_q <= col_d;
      res_q <= res_d;
      n_out_q <= n_out_d;
      m_q <= m_d;
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      ovf_acc_q <= ovf_acc_d;
    end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.n_out = n_out_q;
  assign bus.ovf = ovf_q;
endmodule

// File: doc/mult_m_seq.md
# mult_m_seq

Parametrised sequential successor to the combinational 5x5 int8 matrix multiplier. It computes C = A x B for square signed matrices of runtime size m (1..N) using one shared multiply-accumulate unit, with a start/busy/done handshake. Final elements are range-checked and either wrapped or saturated. It sits between the coprocessor's operand registers and its result bus, and keeps the same flattened operand packing.

## Interface
Parameters:
- N, 5: maximum matrix dimension.
- W, 8: element width, signed two's complement.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; accepted only when busy=0.
- size  in  $clog2(N+1)  runtime dimension m, sampled on the accepted start.
- lin  in  N*N*W  matrix A, row-major, element (0,0) at MSBs, W bits per element; sampled on the accepted start.
- col  in  N*N*W  matrix B, column-major (column 0 at MSBs, element (0,j) first within each column); sampled on the accepted start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- n_out  out  N*N*W  result C, row-major, (0,0) at MSBs.
- ovf  out  1  at least one final element of the last operation fell outside the W-bit signed range.

## Operation
- States:
  - IDLE: start=1 latches lin, col and size; the edge that does this goes to LOAD and sets busy.
  - LOAD: clear the accumulator and the i,j,k counters; clear the internal result register to zero.
  - MAC: acc += A[i][k]*B[k][j] for k=0..m-1, one product per cycle.
  - WRITE: range-check acc and store C[i][j]; increment j (wrapping to 0 and incrementing i); return to MAC, or go to FINISH after (m-1,m-1).
  - FINISH: copy the result register to n_out, register ovf, pulse done, clear busy, go to IDLE.
- Size rules: size=0 or size>N is treated as m=N.
- Unused elements: elements with i>=m or j>=m are zero in n_out.
- Arithmetic widths:
  - Each product is 2W bits signed.
  - The accumulator is ACCW = 2W+$clog2(N) bits signed, so intermediate sums never overflow.
  - The range check applies only to the final acc value.
- ovf: OR of the per-element range flags for the current operation. It is cleared on the accepted start.
- start while busy=1 is ignored and has no side effects.
- A start in the same cycle as FINISH is ignored. A start in the following cycle (IDLE) is accepted.

## Timing
- Edge 0 is the edge that accepts start. busy=1 from edge 0.
- done=1, busy=0 and the new n_out/ovf appear at edge L = 1 + m²(m+1) + 1 = m²(m+1)+2.
  - m=1: L=4. m=2: L=14. m=5: L=152.
- done is high for exactly one cycle.
- n_out and ovf hold their values until the next completion. ovf alone is cleared at the next accepted start.
- Reset (rst=0, at any time): busy=0, done=0, ovf=0, n_out=0, state IDLE, counters and accumulator cleared. An in-flight operation is discarded. Normal operation resumes on the first edge after release.

## Configuration
- MULT_SAT_EN defined: an out-of-range element saturates to +(2^(W-1)-1) or -2^(W-1).
- MULT_SAT_EN undefined: the element takes the low W bits of acc (wrap).
- ovf behaves identically in both builds.

## Structure
- Package matrix_pkg holds:
  - the state enum (IDLE, LOAD, MAC, WRITE, FINISH);
  - a function returning ACCW from W and N;
  - element slice helpers for row-major and column-major indexing;
  - the saturate/wrap function, guarded by MULT_SAT_EN.
- Sub-module mac_elem: signed W x W multiply into an ACCW-bit accumulator, with clear and enable inputs and rst. It replaces the per-element inner-product instances of the combinational design.

## Test plan
- m=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]: C top-left block = 19,22,43,50; all other elements 0; ovf=0; done at edge 14.
- m=5, A=identity, B=values -12..12: n_out equals B in row-major order; ovf=0; done at edge 152; busy high for edges 0..151.
- m=1, A=100, B=2:
  - build without MULT_SAT_EN: element=-56 (0xC8), ovf=1;
  - build with MULT_SAT_EN: element=127, ovf=1;
  - A=-100, B=2: wrap gives 56, saturate gives -128.
- m=2, A row 0=[100,100], B column 0=[1,-1]: C[0][0]=0 and ovf=0, because the intermediate sum of 100 does not flag.
- m=5 start, second start at edge 10 with different data: ignored; the result matches the first operands. A start one cycle after done is accepted and completes normally.
- m=5, rst=0 asserted at edge 40: busy, done, ovf and n_out go to 0 immediately. After release, a fresh m=2 operation produces correct results at edge 14.
